// File: rtl/tlb_op_ctrl.sv
// TLB maintenance op sequencer (SRCH/RD/WR/FILL/INV): latches a request, drives the TLB for one ISSUE cycle, pulses done.
// Define TLB_FILL_RANDOM_EN to pick FILL slots from a free-running LFSR instead of a round-robin counter.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_code,
    input  logic [4:0]    inv_op,
    input  logic [9:0]    inv_asid,
    input  logic [18:0]   inv_vppn,
    input  logic [31:0]   csr_tlbidx,
    input  logic [31:0]   csr_tlbehi,
    input  logic [31:0]   csr_tlbelo0,
    input  logic [31:0]   csr_tlbelo1,
    input  logic [9:0]    csr_asid,
    input  logic          csr_refill,
    output logic [18:0]   tlb_s_vppn,
    output logic          tlb_s_va_bit12,
    output logic [9:0]    tlb_s_asid,
    input  logic          tlb_s_found,
    input  logic [IW-1:0] tlb_s_index,
    output logic          tlb_invtlb_valid,
    output logic [4:0]    tlb_invtlb_op,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic [88:0]   tlb_w_entry,
    output logic [IW-1:0] tlb_r_index,
    input  logic [88:0]   tlb_r_entry,
    output logic          done,
    output logic [2:0]    done_op,
    output logic          res_found,
    output logic [IW-1:0] res_index,
    output logic [88:0]   res_entry
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    state_t state_reg, state_next;

    logic [2:0]    op_reg;
    logic [4:0]    inv_op_reg;
    logic [9:0]    inv_asid_reg;
    logic [18:0]   inv_vppn_reg;
    logic [IW-1:0] idx_reg;
    logic [5:0]    ps_reg;
    logic          ne_reg;
    logic [18:0]   vppn_reg;
    logic [9:0]    asid_reg;
    logic          refill_reg;
    // ELO with the reserved bit 7 squeezed out: [26:7] ppn, [6] g, [5:4] mat, [3:2] plv, [1] d, [0] v
    logic [26:0]   lo0_reg, lo1_reg;
    logic [IW-1:0] fill_idx;
    logic          accept;
    logic          unused_csr_bits;

    assign unused_csr_bits = ^{csr_tlbidx[30], csr_tlbidx[23:IW], csr_tlbehi[12:0],
                               csr_tlbelo0[31:28], csr_tlbelo0[7],
                               csr_tlbelo1[31:28], csr_tlbelo1[7]};

    assign op_ready = resetn && (state_reg == IDLE);
    assign accept   = op_valid && op_ready;
    assign done_op  = op_reg;

    assign tlb_r_index = idx_reg;
    assign tlb_w_index = (op_reg == OP_FILL) ? fill_idx : idx_reg;
    assign tlb_w_entry = {refill_reg | ~ne_reg, ps_reg, vppn_reg, asid_reg, lo0_reg[6] & lo1_reg[6],
                          lo0_reg[26:7], lo0_reg[3:2], lo0_reg[5:4], lo0_reg[1], lo0_reg[0],
                          lo1_reg[26:7], lo1_reg[3:2], lo1_reg[5:4], lo1_reg[1], lo1_reg[0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            inv_op_reg   <= '0;
            inv_asid_reg <= '0;
            inv_vppn_reg <= '0;
            idx_reg      <= '0;
            ps_reg       <= '0;
            ne_reg       <= 1'b0;
            vppn_reg     <= '0;
            asid_reg     <= '0;
            refill_reg   <= 1'b0;
            lo0_reg      <= '0;
            lo1_reg      <= '0;
            res_found    <= 1'b0;
            res_index    <= '0;
            res_entry    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg       <= op_code;
                inv_op_reg   <= inv_op;
                inv_asid_reg <= inv_asid;
                inv_vppn_reg <= inv_vppn;
                idx_reg      <= csr_tlbidx[IW-1:0];
                ps_reg       <= csr_tlbidx[29:24];
                ne_reg       <= csr_tlbidx[31];
                vppn_reg     <= csr_tlbehi[31:13];
                asid_reg     <= csr_asid;
                refill_reg   <= csr_refill;
                lo0_reg      <= {csr_tlbelo0[27:8], csr_tlbelo0[6:0]};
                lo1_reg      <= {csr_tlbelo1[27:8], csr_tlbelo1[6:0]};
            end
            if (state_reg == ISSUE && op_reg == OP_SRCH) begin
                res_found <= tlb_s_found;
                res_index <= tlb_s_index;
            end
            if (state_reg == ISSUE && op_reg == OP_RD) begin
                res_entry <= tlb_r_entry;
            end
        end
    end

    // Strobes decode from the registered state only, so reset removes them combinationally.
    always_comb begin
        state_next       = state_reg;
        tlb_we           = 1'b0;
        tlb_invtlb_valid = 1'b0;
        tlb_invtlb_op    = '0;
        tlb_s_vppn       = '0;
        tlb_s_asid       = '0;
        tlb_s_va_bit12   = 1'b0;
        done             = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                state_next = DONE;
                case (op_reg)
                    OP_SRCH: begin
                        tlb_s_vppn = vppn_reg;
                        tlb_s_asid = asid_reg;
                    end
                    OP_WR, OP_FILL: tlb_we = 1'b1;
                    OP_INV: begin
                        tlb_s_vppn = inv_vppn_reg;
                        tlb_s_asid = inv_asid_reg;
                        if (inv_op_reg <= 5'd6) begin
                            tlb_invtlb_valid = 1'b1;
                            tlb_invtlb_op    = inv_op_reg;
                        end
                    end
                    default: ;
                endcase
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef TLB_FILL_RANDOM_EN
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            5:       return 32'h14;
            6:       return 32'h30;
            7:       return 32'h60;
            8:       return 32'hB8;
            default: return 32'h0C;
        endcase
    endfunction

    localparam int LW = (IW > 4) ? IW : 4;
    localparam logic [LW-1:0] LFSR_TAPS = LW'(lfsr_taps(LW));

    logic [LW-1:0] lfsr_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_reg <= LW'(1);
        else         lfsr_reg <= {lfsr_reg[LW-2:0], ^(lfsr_reg & LFSR_TAPS)};
    end

    assign fill_idx = lfsr_reg[IW-1:0];
`else
    logic [IW-1:0] fill_cnt_reg;

    // Width equals IW and TLBNUM is a power of two, so the increment wraps naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                     fill_cnt_reg <= '0;
        else if (state_reg == ISSUE && op_reg == OP_FILL) fill_cnt_reg <= fill_cnt_reg + 1'b1;
    end

    assign fill_idx = fill_cnt_reg;
`endif
endmodule
